arbiter_rr_merge: RTL

//  Parametrised N-input fair merge arbiter: NUM_IN producer channels feed one consumer channel.

---
 rtl/arbiter_rr_merge.sv | 109 ++++++++++
 1 files changed

// File: rtl/arbiter_rr_merge.sv
// rtl/arbiter_rr_merge.sv - round-robin N:1 flit merge with a one-entry output buffer
// Optional packet lock keeps every flit of a packet contiguous on the output.
module arbiter_rr_merge #(
  parameter  int WIDTH    = 18,
  parameter  int NUM_IN   = 14,
  parameter  int PKT_LOCK = 0,
  parameter  int TAIL_BIT = 0,
  localparam int IDX_W    = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [IDX_W-1:0]        out_src,
  input  logic                    out_ready
);

  typedef enum logic {S_OPEN, S_LOCKED} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] ptr_q, ptr_d, lk_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [IDX_W-1:0] out_src_q;

  logic [WIDTH-1:0] flit [NUM_IN];
  logic [WIDTH-1:0] sel_data;
  logic [IDX_W-1:0] gnt_idx, cand;
  logic             gnt_valid, free, accept, sel_tail;
  int               scan;

  always_comb begin
    for (int i = 0; i < NUM_IN; i++) flit[i] = in_data[i*WIDTH +: WIDTH];
  end

  // Scan downward so the input closest to ptr (in circular order) is the last to win.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    scan      = 0;
    if (state_q == S_LOCKED) begin
      gnt_valid = in_valid[lk_q];
      gnt_idx   = lk_q;
    end else begin
      for (int k = NUM_IN - 1; k >= 0; k--) begin
        scan = int'(ptr_q) + k;
        if (scan >= NUM_IN) scan = scan - NUM_IN;
        cand = IDX_W'(scan);
        if (in_valid[cand]) begin
          gnt_valid = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
  end

  assign sel_data = flit[gnt_idx];
  assign sel_tail = sel_data[TAIL_BIT];
  assign free     = !out_valid_q || out_ready;
  assign accept   = gnt_valid && free;
  assign ptr_d    = (gnt_idx == IDX_W'(NUM_IN - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    in_ready = '0;
    if (accept && !rst) in_ready[gnt_idx] = 1'b1;
  end

  // Accepts while LOCKED come only from lk, so ptr stays at lk+1 for the whole packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_OPEN;
      ptr_q       <= '0;
      lk_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_data;
      out_src_q   <= gnt_idx;
      ptr_q       <= ptr_d;
      if (PKT_LOCK != 0) begin
        case (state_q)
          S_OPEN: begin
            if (!sel_tail) begin
              state_q <= S_LOCKED;
              lk_q    <= gnt_idx;
            end
          end
          S_LOCKED: begin
            if (sel_tail) state_q <= S_OPEN;
          end
          default: state_q <= S_OPEN;
        endcase
      end
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule
